// File: rtl/buzzer_pkg.sv
// Shared encodings for the buzzer scheduler: tone selects, FSM states and the BCD zero used in time matches.
package buzzer_pkg;

  localparam logic [1:0] TONE_NONE  = 2'd0;
  localparam logic [1:0] TONE_CLICK = 2'd1;
  localparam logic [1:0] TONE_CHIME = 2'd2;
  localparam logic [1:0] TONE_ALARM = 2'd3;

  localparam logic [7:0] BCD_ZERO = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLICK = 2'd1,
    CHIME = 2'd2,
    ALARM = 2'd3
  } buzz_state_t;

  function automatic logic [1:0] state_tone(input buzz_state_t s);
    case (s)
      CLICK:   state_tone = TONE_CLICK;
      CHIME:   state_tone = TONE_CHIME;
      ALARM:   state_tone = TONE_ALARM;
      default: state_tone = TONE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bcd_time_match.sv
// Combinational BCD time compare: optional hour match, minute match, and second == 00.
module bcd_time_match
  import buzzer_pkg::*;
(
  input  logic       i_hour_en,
  input  logic [7:0] i_hour,
  input  logic [7:0] i_min,
  input  logic [7:0] i_sec,
  input  logic [7:0] i_tgt_hour,
  input  logic [7:0] i_tgt_min,
  output logic       o_match
);

  assign o_match = (~i_hour_en | (i_hour == i_tgt_hour)) &
                   (i_min == i_tgt_min) &
                   (i_sec == BCD_ZERO);

endmodule

// File: rtl/buzzer_scheduler.sv
// Arbitrates the piezo buzzer between alarm ring, hourly chime and tick/key click.
// States: IDLE silent | CLICK short click | CHIME hourly chime | ALARM ringing, 500 ms on per second
module buzzer_scheduler
  import buzzer_pkg::*;
#(
  parameter int ALARM_SEC   = 30,
  parameter int CHIME_MS    = 200,
  parameter int CLICK_MS    = 20,
  parameter int ALARM_ON_MS = 500
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tick_1ms,
  input  logic       sec_pulse,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
  input  logic [7:0] alarm_hour,
  input  logic [7:0] alarm_min,
  input  logic       have_alarm,
  input  logic       should_tick,
  input  logic       key_valid,
  input  logic [3:0] key_value,
  output logic       buzz_en,
  output logic [1:0] tone_sel,
  output logic       ringing,
  output logic       key_swallow
);

  localparam logic [15:0] LP_CLICK_MS = 16'(CLICK_MS);
  localparam logic [15:0] LP_CHIME_MS = 16'(CHIME_MS);
  localparam logic [15:0] LP_ON_MS    = 16'(ALARM_ON_MS);
  localparam logic [15:0] LP_MS_SAT   = 16'd999;
  localparam logic [7:0]  LP_SEC_END  = 8'(ALARM_SEC);

  buzz_state_t r_state, w_state_nxt;
  logic [15:0] r_ms_cnt, w_ms_nxt, w_limit;
  logic [7:0]  r_sec_cnt, w_sec_nxt;
  logic        r_buzz_en, r_ringing, r_key_swallow;
  logic [1:0]  r_tone_sel;
  logic        w_swallow_nxt, w_enter;
  logic        w_alarm_match, w_chime_match;
  logic        w_alarm_req, w_chime_req, w_click_req;
  logic        w_key_unused;

  // The key code carries no meaning here; only the strobe matters.
  assign w_key_unused = ^key_value;

  bcd_time_match u_alarm_match (
    .i_hour_en  (1'b1),
    .i_hour     (cur_hour),
    .i_min      (cur_min),
    .i_sec      (cur_sec),
    .i_tgt_hour (alarm_hour),
    .i_tgt_min  (alarm_min),
    .o_match    (w_alarm_match)
  );

  bcd_time_match u_chime_match (
    .i_hour_en  (1'b0),
    .i_hour     (cur_hour),
    .i_min      (cur_min),
    .i_sec      (cur_sec),
    .i_tgt_hour (BCD_ZERO),
    .i_tgt_min  (BCD_ZERO),
    .o_match    (w_chime_match)
  );

  assign w_alarm_req = sec_pulse & have_alarm & w_alarm_match;
  assign w_chime_req = sec_pulse & should_tick & w_chime_match;
  assign w_click_req = (sec_pulse & should_tick) | key_valid;
  assign w_limit     = (r_state == CHIME) ? LP_CHIME_MS : LP_CLICK_MS;

  always_comb begin
    w_state_nxt   = r_state;
    w_ms_nxt      = r_ms_cnt;
    w_sec_nxt     = r_sec_cnt;
    w_swallow_nxt = 1'b0;
    w_enter       = 1'b0;
    case (r_state)
      ALARM: begin
        if (key_valid) begin
          w_state_nxt   = IDLE;
          w_swallow_nxt = 1'b1;
          w_enter       = 1'b1;
        end else if (!have_alarm) begin
          w_state_nxt = IDLE;
          w_enter     = 1'b1;
        end else if (sec_pulse) begin
          if (r_sec_cnt + 8'd1 == LP_SEC_END) begin
            w_state_nxt = IDLE;
            w_enter     = 1'b1;
          end else begin
            w_sec_nxt = r_sec_cnt + 8'd1;
            w_ms_nxt  = 16'd0;
          end
        end else if (tick_1ms && (r_ms_cnt < LP_MS_SAT)) begin
          w_ms_nxt = r_ms_cnt + 16'd1;
        end
      end
      default: begin
        // Equal or lower requests are dropped, except a click restarting a click.
        if (w_alarm_req) begin
          w_state_nxt = ALARM;
          w_enter     = 1'b1;
        end else if (w_chime_req && (r_state != CHIME)) begin
          w_state_nxt = CHIME;
          w_enter     = 1'b1;
        end else if (w_click_req && (r_state != CHIME)) begin
          w_state_nxt = CLICK;
          w_enter     = 1'b1;
        end else if ((r_state != IDLE) && tick_1ms) begin
          if (r_ms_cnt + 16'd1 == w_limit) begin
            w_state_nxt = IDLE;
            w_enter     = 1'b1;
          end else begin
            w_ms_nxt = r_ms_cnt + 16'd1;
          end
        end
      end
    endcase
    if (w_enter) begin
      w_ms_nxt  = 16'd0;
      w_sec_nxt = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_ms_cnt      <= 16'd0;
      r_sec_cnt     <= 8'd0;
      r_buzz_en     <= 1'b0;
      r_tone_sel    <= TONE_NONE;
      r_ringing     <= 1'b0;
      r_key_swallow <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ms_cnt      <= w_ms_nxt;
      r_sec_cnt     <= w_sec_nxt;
      r_buzz_en     <= (w_state_nxt == ALARM) ? (w_ms_nxt < LP_ON_MS) : (w_state_nxt != IDLE);
      r_tone_sel    <= state_tone(w_state_nxt);
      r_ringing     <= (w_state_nxt == ALARM);
      r_key_swallow <= w_swallow_nxt;
    end
  end

  assign buzz_en     = r_buzz_en;
  assign tone_sel    = r_tone_sel;
  assign ringing     = r_ringing;
  assign key_swallow = r_key_swallow;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Scoreboard bench for buzzer_scheduler: a countdown model predicts each cycle's outputs.
module tb_buzzer_scheduler;

  logic       clk = 1'b0;
  logic       rstn;
  logic       tick_1ms, sec_pulse, have_alarm, should_tick, key_valid;
  logic [7:0] cur_hour, cur_min, cur_sec, alarm_hour, alarm_min;
  logic [3:0] key_value;
  logic       buzz_en, ringing, key_swallow;
  logic [1:0] tone_sel;

  int n_err = 0;
  int n_chk = 0;

  typedef struct packed {
    logic       buzz;
    logic [1:0] tone;
    logic       ring;
    logic       swal;
  } exp_t;
  exp_t sb_q[$];

  // model: 0 idle, 1 click, 2 chime, 3 alarm
  int m_state, m_left, m_sec_left, m_ms;
  bit m_swal;

  always #5 clk = ~clk;

  buzzer_scheduler dut (
    .clk(clk), .rstn(rstn), .tick_1ms(tick_1ms), .sec_pulse(sec_pulse),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .have_alarm(have_alarm),
    .should_tick(should_tick), .key_valid(key_valid), .key_value(key_value),
    .buzz_en(buzz_en), .tone_sel(tone_sel), .ringing(ringing), .key_swallow(key_swallow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_left = 0; m_sec_left = 0; m_ms = 0; m_swal = 0;
  endtask

  task automatic model_step();
    bit areq, creq, kreq;
    exp_t e;
    areq = sec_pulse & have_alarm & (cur_hour == alarm_hour) & (cur_min == alarm_min) & (cur_sec == 8'h00);
    creq = sec_pulse & should_tick & (cur_min == 8'h00) & (cur_sec == 8'h00);
    kreq = (sec_pulse & should_tick) | key_valid;
    m_swal = 0;
    if (m_state == 3) begin
      if (key_valid) begin m_state = 0; m_swal = 1; end
      else if (!have_alarm) m_state = 0;
      else if (sec_pulse) begin
        m_sec_left--; m_ms = 0;
        if (m_sec_left == 0) m_state = 0;
      end else if (tick_1ms && m_ms < 999) m_ms++;
    end else if (areq) begin
      m_state = 3; m_sec_left = 30; m_ms = 0;
    end else if (creq && m_state != 2) begin
      m_state = 2; m_left = 200;
    end else if (kreq && m_state < 2) begin
      m_state = 1; m_left = 20;
    end else if (m_state != 0 && tick_1ms) begin
      m_left--;
      if (m_left == 0) m_state = 0;
    end
    e.tone = 2'(m_state);
    e.ring = (m_state == 3);
    e.buzz = (m_state == 3) ? (m_ms < 500) : (m_state != 0);
    e.swal = m_swal;
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    chk("sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("buzz_en", buzz_en, e.buzz);
      chk("tone_sel", tone_sel, e.tone);
      chk("ringing", ringing, e.ring);
      chk("key_swallow", key_swallow, e.swal);
    end
    tick_1ms = 0; sec_pulse = 0; key_valid = 0; key_value = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1ms = 1; cyc();
      cyc();
    end
  endtask

  task automatic run_until_idle(input int max, output int n);
    n = 0;
    for (int i = 0; i < max; i++) begin
      tick_1ms = 1; cyc(); n++;
      if (tone_sel == 2'd0) break;
    end
    chk("idle_reached", tone_sel, 0);
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    cur_hour = h; cur_min = m; cur_sec = s;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rstn = 0; tick_1ms = 0; sec_pulse = 0; have_alarm = 0; should_tick = 0;
    key_valid = 0; key_value = 0; alarm_hour = 0; alarm_min = 0;
    set_time(8'h00, 8'h00, 8'h05);
    model_reset();
    #23;
    chk("rst_buzz", buzz_en, 0);
    chk("rst_tone", tone_sel, 0);
    chk("rst_ring", ringing, 0);
    chk("rst_swal", key_swallow, 0);
    @(posedge clk); #1;
    rstn = 1;
    cyc(); cyc();

    // 1: alarm ring at 07:30:00
    have_alarm = 1; alarm_hour = 8'h07; alarm_min = 8'h30;
    set_time(8'h07, 8'h29, 8'h59); sec_pulse = 1; cyc();
    chk("pre_alarm_silent", buzz_en, 0);
    set_time(8'h07, 8'h30, 8'h00); sec_pulse = 1; cyc();
    chk("alarm_ring", ringing, 1);
    chk("alarm_tone", tone_sel, 3);
    ticks(499);
    chk("alarm_ms499_on", buzz_en, 1);
    ticks(1);
    chk("alarm_ms500_off", buzz_en, 0);
    ticks(600);
    for (int i = 1; i < 30; i++) begin
      cur_sec = 8'(i); sec_pulse = 1; cyc();
      ticks(3);
    end
    chk("alarm_29_ring", ringing, 1);
    chk("alarm_newsec_on", buzz_en, 1);
    cur_sec = 8'h30; sec_pulse = 1; cyc();
    chk("alarm_30_end", ringing, 0);
    chk("alarm_30_tone", tone_sel, 0);
    cyc();

    // 2: dismiss with a key
    alarm_min = 8'h31;
    set_time(8'h07, 8'h31, 8'h00); sec_pulse = 1; cyc();
    chk("dismiss_ring", ringing, 1);
    ticks(10);
    key_valid = 1; key_value = 4'd5; cyc();
    chk("dismiss_swallow", key_swallow, 1);
    chk("dismiss_tone", tone_sel, 0);
    cyc();
    chk("dismiss_swallow_1cyc", key_swallow, 0);
    chk("dismiss_no_click", buzz_en, 0);

    // 3: alarm beats chime, chime not replayed after the ring
    alarm_hour = 8'h08; alarm_min = 8'h00; should_tick = 1;
    set_time(8'h08, 8'h00, 8'h00); sec_pulse = 1; cyc();
    chk("beat_tone", tone_sel, 3);
    for (int i = 1; i <= 30; i++) begin
      cur_sec = 8'(i); sec_pulse = 1; cyc();
      ticks(2);
    end
    chk("beat_after_tone", tone_sel, 0);
    cyc(); cyc();

    // 4: hourly chime, key at ms 50 ignored
    have_alarm = 0;
    set_time(8'h09, 8'h00, 8'h00); sec_pulse = 1; cyc();
    chk("chime_tone", tone_sel, 2);
    ticks(50);
    key_valid = 1; key_value = 4'd3; cyc();
    chk("chime_key_tone", tone_sel, 2);
    run_until_idle(400, n);
    chk("chime_len", n, 150);

    // 5: tick click, disabled tick, key click, click restart
    set_time(8'h10, 8'h05, 8'h17); sec_pulse = 1; cyc();
    chk("tick_click_tone", tone_sel, 1);
    run_until_idle(100, n);
    chk("tick_click_len", n, 20);
    should_tick = 0;
    cur_sec = 8'h18; sec_pulse = 1; cyc();
    chk("tick_off_buzz", buzz_en, 0);
    key_valid = 1; key_value = 4'd1; cyc();
    run_until_idle(100, n);
    chk("key_click_len", n, 20);
    key_valid = 1; cyc();
    for (int i = 0; i < 10; i++) begin tick_1ms = 1; cyc(); end
    key_valid = 1; cyc();
    run_until_idle(100, n);
    chk("click_restart_len", n, 20);

    // 6: async reset mid-ring
    have_alarm = 1; alarm_hour = 8'h11; alarm_min = 8'h00;
    set_time(8'h11, 8'h00, 8'h00); sec_pulse = 1; cyc();
    ticks(5);
    chk("rst_mid_pre", ringing, 1);
    #2 rstn = 0;
    #1;
    chk("async_buzz", buzz_en, 0);
    chk("async_ring", ringing, 0);
    chk("async_tone", tone_sel, 0);
    model_reset();
    @(posedge clk); #1;
    rstn = 1;
    for (int i = 0; i < 5; i++) begin tick_1ms = 1; cyc(); end
    chk("post_rst_idle", tone_sel, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
